// File: rtl/pokey_kb_scan_if.sv
// Keypad-side and status signals of the POKEY keypad scanner.
// The scanner uses the slave view; the keypad/host side uses the master view.
interface pokey_kb_scan_if;
  logic       scan_en;
  logic       kr1_n;
  logic [3:0] k_scan;
  logic [3:0] keycode_latch;
  logic       key_down;
  logic       key_irq;

  modport master (
    output scan_en, kr1_n,
    input  k_scan, keycode_latch, key_down, key_irq
  );

  modport slave (
    input  scan_en, kr1_n,
    output k_scan, keycode_latch, key_down, key_irq
  );
endinterface

// File: rtl/pokey_kb_scan.sv
// POKEY 16-position keypad scan engine: walks the scan address, samples the
// synchronized return line once per dwell, and debounces over whole passes.
module pokey_kb_scan #(
  parameter int SCAN_DIV    = 114,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  pokey_kb_scan_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIRM,
    S_DOWN,
    S_RELEASE
  } state_t;

  state_t                 r_state, w_state_nx;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [9:0]             r_cnt;
  logic [3:0]             r_kscan;
  logic [3:0]             r_cand, w_cand_nx;
  logic [3:0]             r_latch, w_latch_nx;
  logic                   r_down, w_down_nx;
  logic                   r_irq, w_irq_nx;
  logic                   w_tc;
  logic                   w_pressed;
  logic                   w_at_cand;

  // Flops reset to all ones so a reset never looks like a pressed key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.kr1_n};
  end

  assign w_pressed = ~r_sync[SYNC_STAGES-1];
  assign w_tc      = (r_cnt == 10'(SCAN_DIV - 1));
  assign w_at_cand = (r_kscan == r_cand);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_kscan <= '0;
    end else if (!bus.scan_en) begin
      r_cnt   <= '0;
      r_kscan <= '0;
    end else if (w_tc) begin
      r_cnt   <= '0;
      r_kscan <= r_kscan + 4'd1;
    end else begin
      r_cnt   <= r_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cand  <= '0;
      r_latch <= '0;
      r_down  <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cand  <= w_cand_nx;
      r_latch <= w_latch_nx;
      r_down  <= w_down_nx;
      r_irq   <= w_irq_nx;
    end
  end

  // Debounce decisions happen only on sample events; position 0 means "no key".
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_latch_nx = r_latch;
    w_down_nx  = r_down;
    w_irq_nx   = 1'b0;
    if (!bus.scan_en) begin
      w_state_nx = S_IDLE;
      w_down_nx  = 1'b0;
    end else if (w_tc && (r_kscan != 4'd0)) begin
      case (r_state)
        S_IDLE: begin
          if (w_pressed) begin
            w_cand_nx  = r_kscan;
            w_state_nx = S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (w_at_cand) begin
            if (w_pressed) begin
              w_latch_nx = r_cand;
              w_down_nx  = 1'b1;
              w_irq_nx   = 1'b1;
              w_state_nx = S_DOWN;
            end else begin
              w_state_nx = S_IDLE;
            end
          end
        end
        S_DOWN: begin
          if (w_at_cand && !w_pressed) w_state_nx = S_RELEASE;
        end
        S_RELEASE: begin
          if (w_at_cand) begin
            if (w_pressed) begin
              w_state_nx = S_DOWN;
            end else begin
              w_down_nx  = 1'b0;
              w_state_nx = S_IDLE;
            end
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign bus.k_scan        = r_kscan;
  assign bus.keycode_latch = r_latch;
  assign bus.key_down      = r_down;
  assign bus.key_irq       = r_irq;

endmodule

// File: tb/tb_pokey_kb_scan.sv
// Bench for pokey_kb_scan: table of pass-level scenarios, hand sequences for
// disable/reset, then random keypad activity against a pass-level model.
module tb_pokey_kb_scan;
  localparam int SD   = 4;
  localparam int PASS = 16 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mask;
  int          checks = 0;
  int          errors = 0;
  int          irq_seen;

  // Model: elapsed enabled cycles plus candidate / accepted / missed-once flags.
  int          m_t;
  int          m_cand;
  bit          m_held;
  bit          m_miss;
  bit          m_irq;
  int          m_latch;

  pokey_kb_scan_if bus();

  assign bus.kr1_n = ~mask[bus.k_scan];

  pokey_kb_scan #(.SCAN_DIV(SD), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mask;
    int          passes;
    int          latch;
    int          down;
    int          irqs;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_cand = 0; m_held = 0; m_miss = 0; m_irq = 0; m_latch = 0;
  endtask

  task automatic model_edge();
    int pos;
    bit pr;
    m_irq = 0;
    if (!bus.scan_en) begin
      m_t = 0; m_cand = 0; m_held = 0; m_miss = 0;
    end else begin
      if (m_t % SD == SD - 1) begin
        pos = (m_t / SD) % 16;
        pr  = mask[pos];
        if (pos != 0) begin
          if (m_cand == 0) begin
            if (pr) m_cand = pos;
          end else if (pos == m_cand) begin
            if (!m_held) begin
              if (pr) begin m_held = 1; m_latch = m_cand; m_irq = 1; end
              else m_cand = 0;
            end else if (pr) begin
              m_miss = 0;
            end else if (m_miss) begin
              m_held = 0; m_miss = 0; m_cand = 0;
            end else begin
              m_miss = 1;
            end
          end
        end
      end
      m_t++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("cyc_k_scan", int'(bus.k_scan), bus.scan_en ? (m_t / SD) % 16 : 0);
    chk("cyc_latch", int'(bus.keycode_latch), m_latch);
    chk("cyc_key_down", int'(bus.key_down), int'(m_held));
    chk("cyc_key_irq", int'(bus.key_irq), int'(m_irq));
    if (bus.key_irq) irq_seen++;
  endtask

  task automatic run_passes(input int n);
    repeat (n * PASS) tick();
  endtask

  initial begin
    vecs[0]  = '{16'h0000, 3, 0,  0, 0};
    vecs[1]  = '{16'h0020, 1, 0,  0, 0};
    vecs[2]  = '{16'h0020, 1, 5,  1, 1};
    vecs[3]  = '{16'h0020, 2, 5,  1, 0};
    vecs[4]  = '{16'h0000, 1, 5,  1, 0};
    vecs[5]  = '{16'h0000, 1, 5,  0, 0};
    vecs[6]  = '{16'h0200, 1, 5,  0, 0};
    vecs[7]  = '{16'h0000, 1, 5,  0, 0};
    vecs[8]  = '{16'h0080, 2, 7,  1, 1};
    vecs[9]  = '{16'h0000, 1, 7,  1, 0};
    vecs[10] = '{16'h0080, 1, 7,  1, 0};
    vecs[11] = '{16'h1080, 2, 7,  1, 0};
    vecs[12] = '{16'h1000, 1, 7,  1, 0};
    vecs[13] = '{16'h1000, 1, 7,  0, 0};
    vecs[14] = '{16'h1000, 1, 12, 1, 1};
    vecs[15] = '{16'h1001, 1, 12, 1, 0};

    rst = 1'b1;
    bus.scan_en = 1'b0;
    mask = 16'h0000;
    model_reset();
    #12;
    chk("reset_k_scan", int'(bus.k_scan), 0);
    chk("reset_latch", int'(bus.keycode_latch), 0);
    chk("reset_key_down", int'(bus.key_down), 0);
    chk("reset_key_irq", int'(bus.key_irq), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.scan_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      mask = vecs[i].mask;
      irq_seen = 0;
      run_passes(vecs[i].passes);
      chk($sformatf("vec%0d_latch", i), int'(bus.keycode_latch), vecs[i].latch);
      chk($sformatf("vec%0d_key_down", i), int'(bus.key_down), vecs[i].down);
      chk($sformatf("vec%0d_irq_count", i), irq_seen, vecs[i].irqs);
    end

    // Disable while confirming key 3: no acceptance survives, latch holds.
    mask = 16'h0000;
    run_passes(2);
    mask = 16'h0008;
    repeat (8 * SD) tick();
    bus.scan_en = 1'b0;
    repeat (3) tick();
    chk("dis_k_scan", int'(bus.k_scan), 0);
    chk("dis_key_down", int'(bus.key_down), 0);
    chk("dis_latch", int'(bus.keycode_latch), 12);
    bus.scan_en = 1'b1;
    irq_seen = 0;
    run_passes(1);
    chk("reen_latch", int'(bus.keycode_latch), 12);
    chk("reen_irq_count", irq_seen, 0);
    irq_seen = 0;
    run_passes(1);
    chk("reen_accept_latch", int'(bus.keycode_latch), 3);
    chk("reen_accept_down", int'(bus.key_down), 1);
    chk("reen_accept_irq", irq_seen, 1);

    // Async reset while key 3 is held, mid-pass.
    repeat (5 * SD) tick();
    chk("pre_rst_k_scan", int'(bus.k_scan), 5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_k_scan", int'(bus.k_scan), 0);
    chk("arst_latch", int'(bus.keycode_latch), 0);
    chk("arst_key_down", int'(bus.key_down), 0);
    chk("arst_key_irq", int'(bus.key_irq), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random keypad activity; keys change only at dwell starts.
    for (int c = 0; c < 6000; c++) begin
      if ((m_t % SD == 0) && ($urandom_range(0, 63) == 0)) begin
        case ($urandom_range(0, 3))
          0:       mask = 16'h0000;
          1:       mask = 16'h0001 << $urandom_range(0, 15);
          2:       mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
          default: mask = 16'h0001 << $urandom_range(1, 15);
        endcase
      end
      if (bus.scan_en && ($urandom_range(0, 999) == 0)) bus.scan_en = 1'b0;
      else if (!bus.scan_en && ($urandom_range(0, 3) == 0)) bus.scan_en = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pokey_kb_scan.md
Name: pokey_kb_scan

Overview:
Keypad scan engine for the POKEY keyboard interface on the 5200-style 16-position keypad. It drives the 4-bit scan address to the external keypad matrix and samples the active-low key-return line. It debounces the return line over whole scan passes and latches the accepted scan position as keycode_latch. keycode_latch feeds the existing KBCODE remap stage, and a one-cycle pulse feeds the keyboard IRQ logic.

Parameters:
SCAN_DIV, 114, clock cycles spent at each scan position (dwell); legal range 4..1023.
SYNC_STAGES, 2, flops in the kr1_n synchronizer; legal range 2..3.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
scan_en  input  1  SKCTL keyboard scan/debounce enable
kr1_n  input  1  key return from keypad, low = key at current scan address pressed
k_scan  output  4  current scan address driven to keypad
keycode_latch  output  4  last accepted key position
key_down  output  1  debounced key-held status (feeds SKSTAT)
key_irq  output  1  one-cycle pulse on each new accepted key

Behaviour:
- One clock. rst is asynchronous and active-high. All state is in the clk domain.
- Reset values: k_scan=0, keycode_latch=0, key_down=0, key_irq=0, dwell counter=0, state=IDLE, cand=0, synchronizer flops=1 (released).
- Dwell counter counts 0..SCAN_DIV-1 while scan_en=1.
- At terminal count (SCAN_DIV-1), the synchronized kr1 is sampled ("sample event"). In the same cycle, k_scan increments mod 16 (15 wraps to 0) and the counter clears.
- The sample belongs to the k_scan value before the increment. One full pass is 16*SCAN_DIV cycles.
- Position 0 means "no key". A sample at position 0 is ignored in every state.
- States, evaluated only on sample events:
  - IDLE: pressed at pos p≠0 -> cand=p, go to CONFIRM.
  - CONFIRM: at pos==cand: pressed -> keycode_latch=cand, key_down=1, key_irq=1 for the next single cycle, go to DOWN. Not pressed -> go to IDLE. Samples at other positions are ignored.
  - DOWN: at pos==cand: not pressed -> go to RELEASE. Presses at other positions are ignored (no rollover, no new latch).
  - RELEASE: at pos==cand: pressed -> go to DOWN (no new irq). Not pressed -> key_down=0, go to IDLE.
- Acceptance latency: exactly one full pass after first detection. key_irq asserts the cycle after the confirming sample event.
- key_irq never asserts for two consecutive cycles. It never re-fires without passing through IDLE.
- keycode_latch changes only on acceptance. It holds its value through release, IDLE and scan_en=0.
- scan_en=0, synchronous, takes effect on the next edge:
  - dwell counter and k_scan forced to 0
  - state forced to IDLE
  - key_down=0 and key_irq=0
  - keycode_latch retained
- Re-enabling scan_en starts a fresh pass at position 0.
- If rst asserts mid-pass or mid-debounce, every output immediately takes its reset value (async). No pending acceptance survives.
- kr1_n is assumed asynchronous. It is used only after SYNC_STAGES flops. SCAN_DIV>=4 guarantees the synchronizer has settled to the new address before the sample event.

Test Plan:
- Reset/idle: rst pulse, scan_en=1, kr1_n=1 for 3 passes (SCAN_DIV=4) -> k_scan cycles 0..15 every 4 clocks and wraps 15->0; keycode_latch=0, key_down=0, key_irq never 1.
- Clean press: kr1_n low whenever k_scan==5 -> CONFIRM after first pos-5 sample; after one more pass keycode_latch=5, key_down=1, exactly one key_irq pulse; while held, no further pulses.
- Bounce: key 9 low only on first pass -> no latch, keycode_latch unchanged, no irq, state back to IDLE.
- Release and glitch: hold key 7 until accepted, then release for one pass -> key_down stays 1 (RELEASE), second absent pass -> key_down=0. A single-pass gap followed by a re-press returns to DOWN with no irq.
- Second key: while 7 is DOWN, also press 12 -> keycode_latch stays 7, no irq. Release 7 fully, keep 12 -> after debounce keycode_latch=12, one irq.
- Disable/reset mid-op: scan_en=0 during CONFIRM -> k_scan=0, no latch, keycode_latch held. Assert rst while DOWN -> all outputs 0 asynchronously, before the next clk edge.
